// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the buffered memory stage.
// IO map, write-buffer entry and registered output bundle.
package mem_stage_pkg;

  localparam int DataW = 24;
  localparam int AddrW = 24;

  localparam int IoSwitchOff = 0;
  localparam int IoGpioBase  = 1;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } wbEntry_t;

  typedef struct packed {
    logic             valid;
    logic             memToReg;
    logic             regWrite;
    logic [1:0]       opType;
    logic [3:0]       opCode;
    logic [3:0]       rc;
    logic [DataW-1:0] data;
    logic [AddrW-1:0] address;
  } outBundle_t;

endpackage

// File: rtl/mem_stage_buffered_store_buffer.sv
// store_buffer: circular store FIFO with an occupancy counter
// and a youngest-match forwarding lookup for loads.
module store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  wbEntry_t         pushEntry,
  input  logic             pop,
  input  logic [AddrW-1:0] lookupAddr,
  output logic             full,
  output logic             empty,
  output wbEntry_t         head,
  output logic             hit,
  output logic [DataW-1:0] hitData
);

  localparam int PtrW = $clog2(DEPTH);

  wbEntry_t        entries [DEPTH];
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic [PtrW:0]   count;
  logic [PtrW-1:0] idx;

  assign full  = count == (PtrW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = entries[rdPtr];

  // pointers wrap naturally; count separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (en) begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry payload; validity comes only from the occupancy
  always_ff @(posedge clk) begin
    if (!rst && en && push) entries[wrPtr] <= pushEntry;
  end

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PtrW'(i);
      if ((PtrW+1)'(i) < count &&
          entries[idx].addr == lookupAddr) begin
        hit     = 1'b1;
        hitData = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/mem_stage_buffered.sv
// mem_stage_buffered: memory stage with a store buffer,
// single-port synchronous RAM, IO reads and 1-cycle output.
module mem_stage_buffered
  import mem_stage_pkg::*;
#(
  parameter int DATA_W    = DataW,
  parameter int ADDR_W    = AddrW,
  parameter int MEM_DEPTH = 1024,
  parameter int WB_DEPTH  = 4,
  parameter int GPIO_CH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    memWrite,
  input  logic                    memToReg,
  input  logic                    regWrite,
  input  logic [1:0]              opType,
  input  logic [3:0]              opCode,
  input  logic [ADDR_W-1:0]       address,
  input  logic [3:0]              Rc,
  input  logic [DATA_W-1:0]       writeData,
  input  logic [3:0]              switches,
  input  logic [GPIO_CH-1:0][35:0] gpio,
  output logic                    out_valid,
  output logic                    out_memToReg,
  output logic                    out_regWrite,
  output logic [1:0]              out_opType,
  output logic [3:0]              out_opCode,
  output logic [3:0]              out_Rc,
  output logic [DATA_W-1:0]       out_data,
  output logic [ADDR_W-1:0]       out_address,
  output logic                    wb_empty
);

  localparam int IdxW = $clog2(MEM_DEPTH);

  logic              isIo;
  logic              isLoad;
  logic              ramLoad;
  logic              ramStore;
  logic              accept;
  logic              ramLoadAcc;
  logic              drain;
  logic              wbFull;
  logic              wbEmpty;
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;
  logic [DATA_W-1:0] ioData;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] ramQ;
  logic [ADDR_W-2:0] ioOff;
  wbEntry_t          head;
  wbEntry_t          pushEntry;
  outBundle_t        outB;
  logic              outFromRam;
  logic              unusedBits;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign isIo       = address[ADDR_W-1];
  assign ioOff      = address[ADDR_W-2:0];
  assign isLoad     = memToReg & ~memWrite;
  assign ramLoad    = isLoad & ~isIo;
  assign ramStore   = memWrite & ~isIo;
  assign in_ready   = ~(ramStore & wbFull);
  assign accept     = en & in_valid & in_ready;
  assign ramLoadAcc = accept & ramLoad;
  assign drain      = en & ~ramLoadAcc & ~wbEmpty;
  assign pushEntry  = '{addr: address, data: writeData};

  store_buffer #(
    .DEPTH(WB_DEPTH)
  ) u_wb (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .push      (accept & ramStore),
    .pushEntry (pushEntry),
    .pop       (drain),
    .lookupAddr(address),
    .full      (wbFull),
    .empty     (wbEmpty),
    .head      (head),
    .hit       (fwdHit),
    .hitData   (fwdData)
  );

  // IO read mux: switches at offset 0, GPIO channels after it
  always_comb begin
    ioData = '0;
    if (ioOff == (ADDR_W-1)'(IoSwitchOff))
      ioData = DATA_W'(switches);
    for (int k = 0; k < GPIO_CH; k++)
      if (ioOff == (ADDR_W-1)'(IoGpioBase + k))
        ioData = gpio[k][DATA_W-1:0];
  end

  // registered data source; RAM misses come from ramQ later
  always_comb begin
    loadData = writeData;
    unique case (1'b1)
      isLoad & isIo:    loadData = ioData;
      ramLoad & fwdHit: loadData = fwdData;
      default:          loadData = writeData;
    endcase
  end

  // output bundle register, valid only on accepted cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      outB       <= '0;
      outFromRam <= 1'b0;
    end else if (en) begin
      outB.valid <= accept;
      if (accept) begin
        outB.memToReg <= memToReg;
        outB.regWrite <= regWrite;
        outB.opType   <= opType;
        outB.opCode   <= opCode;
        outB.rc       <= Rc;
        outB.data     <= loadData;
        outB.address  <= address;
        outFromRam    <= ramLoad & ~fwdHit;
      end
    end
  end

  // single RAM port: accepted load reads, else buffer drains
  always_ff @(posedge clk) begin
    if (!rst && en) begin
      if (ramLoadAcc)
        ramQ <= mem[address[IdxW-1:0]];
      else if (drain)
        mem[head.addr[IdxW-1:0]] <= head.data;
    end
  end

  assign out_valid    = outB.valid;
  assign out_memToReg = outB.memToReg;
  assign out_regWrite = outB.regWrite;
  assign out_opType   = outB.opType;
  assign out_opCode   = outB.opCode;
  assign out_Rc       = outB.rc;
  assign out_address  = outB.address;
  assign out_data     = outFromRam ? ramQ : outB.data;
  assign wb_empty     = wbEmpty;

  assign unusedBits = ^{gpio, head.addr};

endmodule
